serial_right_shifter: RTL and testbench

SERIAL_RIGHT_SHIFTER -- requirements
Module: serial_right_shifter

---
 rtl/serial_right_shifter.sv | 94 +++++++++
 tb/tb_serial_right_shifter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_right_shifter.sv
// Serial right shifter: moves the operand one bit per cycle through an IDLE/SHIFT/DONE FSM.
// Optional arithmetic fill enabled by defining SERIAL_RIGHT_SHIFTER_ARITH_EN (adds the arith port).
module serial_right_shifter #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_amt,
`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
    input  logic          arith,
`endif
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_data;
    logic [SW-1:0] r_cnt;
    logic          w_accept;
    logic          w_fill;

    assign up_ready   = (r_state == IDLE);
    assign down_valid = (r_state == DONE);
    assign down_data  = r_data;
    assign w_accept   = up_valid & up_ready;

`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
    logic r_arith;

    // Mode is latched at accept so a toggling arith input cannot corrupt an operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_arith <= 1'b0;
        else if (w_accept)
            r_arith <= arith;
    end

    assign w_fill = r_arith & r_data[N-1];
`else
    assign w_fill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = (up_amt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (r_cnt == SW'(1))
                    w_state_nxt = DONE;
            end
            DONE: begin
                if (down_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_data <= up_data;
            r_cnt  <= up_amt;
        end else if (r_state == SHIFT) begin
            r_data <= {w_fill, r_data[N-1:1]};
            r_cnt  <= r_cnt - SW'(1);
        end
    end

endmodule

// File: tb/tb_serial_right_shifter.sv
// Directed bench for serial_right_shifter (N=8): latency, result, hold, reset abort, input isolation.
module tb_serial_right_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic [2:0] up_amt;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;
`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
    logic       arith = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_right_shifter #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amt     (up_amt),
`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
        .arith      (arith),
`endif
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: accept, scramble inputs while busy, measure latency, hold DONE, release.
    task automatic op(input logic [7:0] d, input logic [2:0] a, input logic [7:0] exp, input int hold);
        int lat;
        @(negedge clk);
        chk("ready_idle", {31'd0, up_ready}, 32'd1);
        up_valid = 1'b1; up_data = d; up_amt = a; down_ready = 1'b0;
        @(posedge clk); #1;
        up_data = ~d; up_amt = ~a;
`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
        arith = ~arith;
`endif
        lat = 0;
        @(negedge clk);
        while (!down_valid && lat < 20) begin
            lat++;
            up_valid = ~up_valid;
            @(negedge clk);
        end
        up_valid = 1'b1;
        chk("latency", lat, {29'd0, a});
        chk("result", {24'd0, down_data}, {24'd0, exp});
        chk("ready_busy", {31'd0, up_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, down_valid}, 32'd1);
            chk("hold_data", {24'd0, down_data}, {24'd0, exp});
            chk("hold_ready", {31'd0, up_ready}, 32'd0);
        end
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        @(negedge clk);
        // up_valid was high at the release edge: it must not have been accepted there
        chk("back_idle", {30'd0, up_ready, down_valid}, 32'd2);
        up_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [2:0] a;
        rst_n = 1'b0; up_valid = 1'b0; up_data = '0; up_amt = '0; down_ready = 1'b0;
        #1;
        chk("rst_ready", {31'd0, up_ready}, 32'd1);
        chk("rst_valid", {31'd0, down_valid}, 32'd0);
        chk("rst_data", {24'd0, down_data}, 32'd0);
        #13 rst_n = 1'b1;

        op(8'hB5, 3'd3, 8'h16, 0);
        op(8'hFF, 3'd0, 8'hFF, 0);
        op(8'h80, 3'd7, 8'h01, 5);
        op(8'h5A, 3'd1, 8'h2D, 1);
        op(8'hC3, 3'd4, 8'h0C, 2);
        op(8'h01, 3'd1, 8'h00, 0);
        op(8'h7F, 3'd2, 8'h1F, 0);
        op(8'hAA, 3'd5, 8'h05, 3);

        // Reset in the middle of a 6-bit shift
        @(negedge clk);
        up_valid = 1'b1; up_data = 8'hF0; up_amt = 3'd6;
        @(posedge clk); #1 up_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, up_ready}, 32'd1);
        chk("abort_valid", {31'd0, down_valid}, 32'd0);
        chk("abort_data", {24'd0, down_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale", {30'd0, up_ready, down_valid}, 32'd2);
        end

        // Reset release followed immediately by an accept
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        op(8'h3C, 3'd2, 8'h0F, 0);

`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
        arith = 1'b1; op(8'h90, 3'd2, 8'hE4, 0);
        arith = 1'b0; op(8'h90, 3'd2, 8'h24, 0);
        arith = 1'b1; op(8'h80, 3'd7, 8'hFF, 1);
        arith = 1'b1; op(8'h70, 3'd3, 8'h0E, 0);
        arith = 1'b0;
`endif

        // Back-to-back operations with random amounts and random downstream stalls
        for (int k = 0; k < 200; k++) begin
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
            arith = 1'b0;
`endif
            op(d, a, d >> a, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
